// File: rtl/dma_dev_port.sv
// dma_dev_port: device-side DMA front end with a local FIFO. Optional watchdog via DMA_DEV_PORT_TIMEOUT_EN.
module dma_dev_port #(
   parameter int ADD_LEN   = 16,
   parameter int DATA_LEN  = 16,
   parameter int BUF_DEPTH = 3,
   parameter int TIMEOUT_W = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   input  logic                cmd_rd_wr,
   input  logic [ADD_LEN:0]    cmd_addr,
   input  logic [ADD_LEN-1:0]  cmd_words,
   output logic                cmd_ready,
   input  logic                wr_valid,
   input  logic [DATA_LEN-1:0] wr_data,
   output logic                wr_ready,
   output logic                rd_valid,
   output logic [DATA_LEN-1:0] rd_data,
   input  logic                rd_ready,
   output logic                done,
   output logic                aborted,
   output logic [ADD_LEN-1:0]  num_words,
   output logic [ADD_LEN:0]    start_addr,
   output logic                rd_wr,
   output logic                rqst,
   output logic                dev_ack,
   output logic [DATA_LEN-1:0] dev_in,
   input  logic                dma_ack,
   input  logic [DATA_LEN-1:0] dev_out,
   input  logic                end_flag
);
   localparam int DEPTH = 1 << BUF_DEPTH;
   localparam logic [BUF_DEPTH:0] HIGH = (BUF_DEPTH+1)'(DEPTH - 1);
   typedef enum logic [2:0] {IDLE, REQ, XFER_WR, XFER_RD, WAIT_END, DONE} state_t;
   state_t st;
   logic [DATA_LEN-1:0] mem [DEPTH];
   logic [BUF_DEPTH:0] wp, rp, level;
   logic [ADD_LEN-1:0] cnt, cnt_nx;
   logic full, empty, push, pop, drop, ovf, xfer, last, ack_ok, start, timeout, finish;

   assign start   = st == IDLE && cmd_valid;
   assign level   = wp - rp;
   assign empty   = wp == rp;
   assign full    = wp[BUF_DEPTH] != rp[BUF_DEPTH] && wp[BUF_DEPTH-1:0] == rp[BUF_DEPTH-1:0];
   assign xfer    = st == XFER_WR || st == XFER_RD;
   assign last    = cnt == num_words;
   // a controller ack counts even while dev_ack is low, but never past num_words
   assign ack_ok  = xfer && !last && dma_ack;
   assign cnt_nx  = cnt + ADD_LEN'(ack_ok);
   assign wr_ready = st == XFER_WR && !full;
   assign rd_valid = rd_wr && !empty;
   assign pop     = (rd_valid && rd_ready) || (st == XFER_WR && ack_ok && !empty);
   assign push    = (st == XFER_WR && wr_valid && wr_ready) || (st == XFER_RD && ack_ok && (!full || pop));
   assign drop    = st == XFER_RD && ack_ok && full && !pop;
   // read direction keeps one free slot because a word may arrive a cycle after dev_ack drops
   assign dev_ack = !timeout && xfer && !last && (st == XFER_WR ? !empty : level < HIGH);
   assign dev_in  = empty ? '0 : mem[rp[BUF_DEPTH-1:0]];
   assign rd_data = dev_in;
   assign finish  = st != IDLE && st != DONE && (end_flag || timeout);

`ifdef DMA_DEV_PORT_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wd;
   assign timeout = (xfer || st == WAIT_END) && &wd;
   // watchdog restarts on every exchanged word and on each new request
   always_ff @(posedge clk or posedge reset)
      if (reset) wd <= '0;
      else if (start || dma_ack) wd <= '0;
      else if (xfer || st == WAIT_END) wd <= wd + 1'b1;
`else
   assign timeout = 1'b0;
`endif

   // FIFO storage, written on accepted pushes only
   always_ff @(posedge clk)
      if (push) mem[wp[BUF_DEPTH-1:0]] <= st == XFER_RD ? dev_out : wr_data;

   // FIFO pointers; cleared when a new command is accepted
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else if (start) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end

   // control FSM with registered handshake and status outputs
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st <= IDLE;
         cmd_ready <= 1'b1;
         rqst <= 1'b0;
         done <= 1'b0;
         aborted <= 1'b0;
         num_words <= '0;
         start_addr <= '0;
         rd_wr <= 1'b0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         rqst <= 1'b0;
         done <= 1'b0;
         aborted <= 1'b0;
         cnt <= start ? '0 : cnt_nx;
         ovf <= start ? 1'b0 : ovf | drop;
         if (start) begin
            st <= REQ;
            cmd_ready <= 1'b0;
            rqst <= 1'b1;
            num_words <= cmd_words;
            start_addr <= cmd_addr;
            rd_wr <= cmd_rd_wr;
         end else if (finish) begin
            st <= DONE;
            done <= 1'b1;
            aborted <= timeout || ovf || drop || cnt_nx != num_words || num_words == '0;
         end else if (st == REQ) st <= rd_wr ? XFER_RD : XFER_WR;
         else if (xfer && last) st <= WAIT_END;
         else if (st == DONE) begin
            st <= IDLE;
            cmd_ready <= 1'b1;
         end
      end
endmodule
